// File: rtl/dad_mem_pkg.sv
// Shared types and default I/O addresses for the dad_mem_ctrl data memory.
package dad_mem_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_OUT,
    REG_IN,
    REG_NONE
  } region_t;

  localparam logic [31:0] DEF_OUT_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] DEF_IN_ADDR  = 32'hFFFF_FFF1;

endpackage

// File: rtl/dad_mem_ctrl_if.sv
// Ready/valid request and registered response bus of the data memory.
interface dad_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dad_mem_ram.sv
// DEPTH x DATA_W RAM: one byte-masked write port, one synchronous read port.
module dad_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Only the output register is reset; the array is zeroed by the clear sequence.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end
endmodule

// File: rtl/dad_mem_ctrl.sv
// Data memory with hardware clear, registered reads and two memory-mapped I/O words.
// Define DMEM_BYTE_WRITE_EN to honour byte enables; otherwise every write is a full word.
module dad_mem_ctrl
  import dad_mem_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 256,
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(DEF_OUT_ADDR),
  parameter logic [ADDR_W-1:0] IN_ADDR  = ADDR_W'(DEF_IN_ADDR)
) (
  input  logic               clock,
  input  logic               resetn,
  dad_mem_ctrl_if.slave      bus,
  input  logic [DATA_W-1:0]  in_port,
  output logic [DATA_W-1:0]  out_port,
  output logic               out_stb
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;

  state_t              state, state_nx;
  region_t             region, rd_region;
  logic [AW-1:0]       clr_cnt;
  logic [NB-1:0]       be_eff;
  logic                acc;
  logic                ram_we, ram_re;
  logic [AW-1:0]       ram_waddr;
  logic [DATA_W-1:0]   ram_wdata, ram_q, io_q;
  logic [NB-1:0]       ram_wbe;

`ifdef DMEM_BYTE_WRITE_EN
  assign be_eff = bus.be;
`else
  assign be_eff = bus.be | '1;
`endif

  always_comb begin
    if (bus.addr == OUT_ADDR)               region = REG_OUT;
    else if (bus.addr == IN_ADDR)           region = REG_IN;
    else if (bus.addr < ADDR_W'(DEPTH))     region = REG_RAM;
    else                                    region = REG_NONE;
  end

  assign acc = bus.req && (state == IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= CLEAR;
    else         state <= state_nx;
  end

  // The clear sequence owns the RAM write port while in CLEAR.
  always_comb begin
    state_nx  = state;
    bus.ready = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = bus.addr[AW-1:0];
    ram_wdata = bus.wdata;
    ram_wbe   = be_eff;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
        ram_wdata = '0;
        ram_wbe   = '1;
        if (clr_cnt == AW'(DEPTH - 1)) state_nx = IDLE;
      end
      IDLE: begin
        bus.ready = 1'b1;
        if (acc && region == REG_RAM) begin
          ram_we = bus.we;
          ram_re = !bus.we;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clr_cnt    <= '0;
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      out_port   <= '0;
      out_stb    <= 1'b0;
      rd_region  <= REG_NONE;
      io_q       <= '0;
    end else begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      out_stb    <= 1'b0;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (acc) begin
        bus.err <= (region == REG_NONE);
        if (!bus.we) begin
          bus.rvalid <= 1'b1;
          rd_region  <= region;
          case (region)
            REG_OUT: io_q <= out_port;
            REG_IN:  io_q <= in_port;
            default: io_q <= '0;
          endcase
        end else if (region == REG_OUT) begin
          out_stb <= 1'b1;
          for (int unsigned i = 0; i < NB; i++) begin
            if (be_eff[i]) out_port[8*i +: 8] <= bus.wdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign bus.rdata = (rd_region == REG_RAM) ? ram_q : io_q;

  dad_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clock  (clock),
    .resetn (resetn),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .wbe    (ram_wbe),
    .re     (ram_re),
    .raddr  (bus.addr[AW-1:0]),
    .rdata  (ram_q)
  );
endmodule

// File: tb/tb_dad_mem_ctrl.sv
// Scoreboard bench for dad_mem_ctrl with DEPTH=16, DATA_W=32.
module tb_dad_mem_ctrl;
  localparam int DW    = 32;
  localparam int AWD   = 32;
  localparam int DEPTH = 16;
  localparam logic [31:0] OUT_A = 32'hFFFF_FFF0;
  localparam logic [31:0] IN_A  = 32'hFFFF_FFF1;
`ifdef DMEM_BYTE_WRITE_EN
  localparam logic [31:0] EXP_BE = 32'hAA22CC44;
`else
  localparam logic [31:0] EXP_BE = 32'h11223344;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic        out_stb;

  always #5 clock = ~clock;

  dad_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AWD)) bus ();

  dad_mem_ctrl #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AWD)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus.slave),
    .in_port  (in_port),
    .out_port (out_port),
    .out_stb  (out_stb)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q [$];   // {err, rdata} per expected read response
  logic wr_err_exp = 1'b0;
  logic wr_stb_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic unmapped(input logic [31:0] a);
    return (a != OUT_A) && (a != IN_A) && (a >= 32'(DEPTH));
  endfunction

  // Expected write side-effects derived from the accepted request.
  always @(posedge clock) begin
    wr_stb_exp = bus.req && bus.ready && bus.we && (bus.addr == OUT_A);
    wr_err_exp = bus.req && bus.ready && bus.we && unmapped(bus.addr);
  end

  always @(negedge clock) begin
    logic [32:0] e;
    if (resetn) begin
      if (bus.rvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rvalid: got rdata %h expected no response", bus.rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", bus.rdata, e[31:0]);
          chk("read_err", 32'(bus.err), 32'(e[32]));
        end
      end else begin
        chk("write_err", 32'(bus.err), 32'(wr_err_exp));
      end
      chk("out_stb", 32'(out_stb), 32'(wr_stb_exp));
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.be    = b;
    @(posedge clock);
    #1;
    bus.req   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic e);
    exp_q.push_back({e, exp});
    issue(1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      @(posedge clock);
      #1;
      cnt++;
    end while (!bus.ready && cnt < 200);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    resetn    = 1'b0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;
    in_port   = '0;
    #1;
    chk("rst_ready",    32'(bus.ready),  32'h0);
    chk("rst_rvalid",   32'(bus.rvalid), 32'h0);
    chk("rst_rdata",    bus.rdata,       32'h0);
    chk("rst_err",      32'(bus.err),    32'h0);
    chk("rst_out_port", out_port,        32'h0);
    chk("rst_out_stb",  32'(out_stb),    32'h0);
    repeat (2) @(posedge clock);

    // Release reset; a read held on the bus during the clear must be ignored.
    @(negedge clock);
    resetn   = 1'b1;
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'd3;
    wait_ready(cnt);
    bus.req  = 1'b0;
    chk("clear_cycles", 32'(cnt), 32'd16);

    rd(32'd7,  32'h0, 1'b0);
    rd(32'd0,  32'h0, 1'b0);
    rd(32'd15, 32'h0, 1'b0);

    issue(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
    rd(32'd5, 32'hDEADBEEF, 1'b0);

    issue(1'b1, 32'd2, 32'hAABBCCDD, 4'hF);
    issue(1'b1, 32'd2, 32'h11223344, 4'b0101);
    rd(32'd2, EXP_BE, 1'b0);
    rd(32'd5, 32'hDEADBEEF, 1'b0);
    rd(32'd7, 32'h0, 1'b0);

    issue(1'b1, OUT_A, 32'h0000_00FF, 4'hF);
    chk("out_port_wr", out_port, 32'h0000_00FF);
    rd(OUT_A, 32'h0000_00FF, 1'b0);
    in_port = 32'h0000_1234;
    rd(IN_A, 32'h0000_1234, 1'b0);
    in_port = 32'h0000_5555;
    issue(1'b1, IN_A, 32'hFFFF_FFFF, 4'hF);
    rd(IN_A, 32'h0000_5555, 1'b0);

    rd(32'd20, 32'h0, 1'b1);
    issue(1'b1, 32'd20, 32'hCAFEF00D, 4'hF);
    rd(32'd4, 32'h0, 1'b0);
    rd(32'd5, 32'hDEADBEEF, 1'b0);
    chk("out_port_held", out_port, 32'h0000_00FF);

    // Restart the clear, then interrupt it at word 9.
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (9) @(posedge clock);
    #1;
    resetn = 1'b0;
    chk("rst2_ready",    32'(bus.ready), 32'h0);
    chk("rst2_out_port", out_port,       32'h0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    wait_ready(cnt);
    chk("reclear_cycles", 32'(cnt), 32'd16);
    chk("reclear_out_port", out_port, 32'h0);
    rd(32'd5, 32'h0, 1'b0);
    rd(32'd2, 32'h0, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("responses_outstanding", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dad_mem_ctrl.md
# dad_mem_ctrl

Parametrised, word-addressed data memory for the processor datapath, with a registered read port, a ready/valid request interface, optional byte-enable writes and two memory-mapped I/O words: an output register and an input sample port. After reset it runs a hardware clear sequence that zeroes every word before accepting requests. It sits between the execute stage and the writeback multiplexer and drives the board output display port.

## Interface
- DATA_W, 32, data word width; multiple of 8
- DEPTH, 256, number of RAM words; power of two, at least 4
- ADDR_W, 32, address width (word address)
- OUT_ADDR, 32'hFFFF_FFF0, word address of the output register
- IN_ADDR, 32'hFFFF_FFF1, word address of the input port
- clock  in  1  single clock; all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  1  request valid; accepted only when ready=1
- we  in  1  1 = write, 0 = read
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- be  in  DATA_W/8  byte enables, bit i covers wdata[8i+7:8i]
- in_port  in  DATA_W  external input word
- ready  out  1  block can accept a request
- rvalid  out  1  one-cycle pulse, rdata valid
- rdata  out  DATA_W  read data, held until the next read completes
- err  out  1  one-cycle pulse: access to an unmapped address
- out_port  out  DATA_W  output register contents
- out_stb  out  1  one-cycle pulse, out_port updated

## Operation
- FSM states: CLEAR, IDLE.
- Reset (async assert): state=CLEAR, clear counter=0, ready=0, rvalid=0, rdata=0, err=0, out_port=0, out_stb=0.
- CLEAR: each cycle writes 0 to RAM[counter], counter+1; after writing word DEPTH-1, go to IDLE. Requests in CLEAR are ignored, with no response.
- IDLE: ready=1; one request per cycle; accepted when req=1 on a rising edge.
- Decode order: addr==OUT_ADDR, then addr==IN_ADDR, then addr<DEPTH for RAM, otherwise unmapped.
- RAM write: bytes with be[i]=1 are updated; others keep their old value.
- RAM read: rdata = RAM[addr[log2(DEPTH)-1:0]].
- OUT_ADDR write: out_port updated under the same byte-enable rules; out_stb pulses.
- OUT_ADDR read: returns current out_port.
- IN_ADDR read: returns in_port sampled at the accepting edge.
- IN_ADDR write: silently dropped; no err.
- Unmapped write: dropped; err pulses.
- Unmapped read: rdata=0, rvalid and err pulse together.
- RAM contents are not reset except by the CLEAR sequence. resetn asserted during CLEAR restarts the clear from word 0.

## Timing
- Clear duration: DEPTH cycles after resetn deasserts; ready rises in the cycle after word DEPTH-1 is written.
- Read latency: 1. Request at edge N gives rvalid/rdata/err valid after edge N+1 and held for one cycle; rdata is held afterwards.
- Write: RAM/out_port updated at the accepting edge. out_stb/err are high for the cycle after that edge.
- Read at edge N+1 of an address written at edge N returns the new data.
- Back-to-back reads: one rvalid per cycle.

## Configuration
- DMEM_BYTE_WRITE_EN
  - Defined: be is honoured for RAM and out_port writes.
  - Undefined: be is ignored and every write is a full word; the port stays present but unused.

## Structure
- Package dad_mem_pkg holds:
  - state enum (CLEAR, IDLE)
  - region decode enum (RAM, OUT, IN, NONE)
  - default OUT_ADDR/IN_ADDR constants
- Sub-module dad_mem_ram: DEPTH x DATA_W array with one byte-masked write port and a synchronous read. The clear path muxes into its write port.

## Test plan
Parameters DEPTH=16, DATA_W=32.
1. Release resetn → ready low for 16 cycles, then high; a read of any RAM word returns 0 with rvalid one cycle later.
2. Write 0xDEADBEEF to addr 5, read addr 5 next cycle → rdata=0xDEADBEEF one cycle after the read.
3. With DMEM_BYTE_WRITE_EN, write 0x11223344 to addr 2 with be=4'b0101 over 0xAABBCCDD → read returns 0xAA22CC44. Without the macro → read returns 0x11223344.
4. Write 0x0000_00FF to OUT_ADDR → out_port=0xFF and out_stb high for exactly one cycle. Hold in_port=0x1234 and read IN_ADDR → rdata=0x1234.
5. Read addr 20 → rvalid=1, err=1, rdata=0. Write addr 20 → err=1 and no RAM word changes.
6. Assert resetn low at clear word 9 for 1 cycle → ready rises 16 cycles after release, and out_port=0.
